servo_pwm_decoder: RTL

//  Receive-side counterpart of the servo PWM generator: measures the high time and frame period of an

---
 rtl/servo_pwm_decoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures pulse high time and frame period in clk_1m ticks.
// Optional glitch filter on the synchronized input is enabled by SERVO_GLITCH_FILT_EN.
module servo_pwm_decoder #(
  parameter logic [31:0] MIN_WIDTH  = 32'd500,
  parameter logic [31:0] MAX_WIDTH  = 32'd2500,
  parameter logic [31:0] PERIOD     = 32'd20000,
  parameter logic [31:0] PERIOD_TOL = 32'd200,
  parameter logic [31:0] TIMEOUT    = 32'd60000,
  parameter logic [31:0] FILT_LEN   = 32'd3
) (
  input  logic        clk_1m,
  input  logic        rst,
  input  logic        angle_sig,
  output logic [31:0] pulse_width,
  output logic [31:0] period,
  output logic        width_valid,
  output logic        frame_err,
  output logic        signal_lost
);

`ifdef SERVO_GLITCH_FILT_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Input path is left unreset so a reset while the pin is high cannot fake a rising edge.
  logic s1, s2, lvl, lvl_d;
  always_ff @(posedge clk_1m) begin
    s1    <= angle_sig;
    s2    <= s1;
    lvl_d <= lvl;
  end

  generate
    if (FILT_ON && FILT_LEN != 32'd0) begin : g_filt
      logic        f;
      logic [31:0] fcnt;
      always_ff @(posedge clk_1m) begin
        if (s2 != f) begin
          if (fcnt >= FILT_LEN - 32'd1) begin
            f    <= s2;
            fcnt <= '0;
          end else begin
            fcnt <= fcnt + 32'd1;
          end
        end else begin
          fcnt <= '0;
        end
      end
      assign lvl = f;
    end else begin : g_nofilt
      assign lvl = s2;
    end
  endgenerate

  logic rise, fall;
  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  state_t      state, state_n;
  logic [31:0] hi_cnt, hi_n, per_cnt, per_n, width_meas, wm_n, pw_n, pd_n;
  logic        wv_n, fe_n, sl_n, frame_ok;

  assign frame_ok = (width_meas >= MIN_WIDTH) && (width_meas <= MAX_WIDTH) &&
                    (per_cnt >= PERIOD - PERIOD_TOL) && (per_cnt <= PERIOD + PERIOD_TOL);

  always_ff @(posedge clk_1m) begin
    if (rst) begin
      state       <= IDLE;
      hi_cnt      <= '0;
      per_cnt     <= '0;
      width_meas  <= '0;
      pulse_width <= '0;
      period      <= '0;
      width_valid <= 1'b0;
      frame_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      state       <= state_n;
      hi_cnt      <= hi_n;
      per_cnt     <= per_n;
      width_meas  <= wm_n;
      pulse_width <= pw_n;
      period      <= pd_n;
      width_valid <= wv_n;
      frame_err   <= fe_n;
      signal_lost <= sl_n;
    end
  end

  always_comb begin
    state_n = state;
    hi_n    = hi_cnt;
    per_n   = per_cnt;
    wm_n    = width_meas;
    pw_n    = pulse_width;
    pd_n    = period;
    wv_n    = 1'b0;
    fe_n    = 1'b0;
    sl_n    = signal_lost;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          hi_n    = 32'd1;
          per_n   = 32'd1;
        end
      end
      HIGH: begin
        hi_n  = (hi_cnt  < TIMEOUT) ? hi_cnt  + 32'd1 : hi_cnt;
        per_n = (per_cnt < TIMEOUT) ? per_cnt + 32'd1 : per_cnt;
        if (fall) begin
          state_n = LOW;
          wm_n    = hi_cnt;
        end else if (hi_cnt >= TIMEOUT) begin
          state_n = IDLE;
          sl_n    = 1'b1;
          hi_n    = '0;
          per_n   = '0;
        end
      end
      LOW: begin
        per_n = (per_cnt < TIMEOUT) ? per_cnt + 32'd1 : per_cnt;
        // A rise landing on the timeout cycle still closes the frame.
        if (rise) begin
          pd_n = per_cnt;
          if (frame_ok) begin
            pw_n = width_meas;
            wv_n = 1'b1;
            sl_n = 1'b0;
          end else begin
            fe_n = 1'b1;
          end
          state_n = HIGH;
          hi_n    = 32'd1;
          per_n   = 32'd1;
        end else if (per_cnt >= TIMEOUT) begin
          state_n = IDLE;
          sl_n    = 1'b1;
          hi_n    = '0;
          per_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
